// File: rtl/pwm_serializer.sv
// rtl/pwm_serializer.sv - fixed-frequency PWM generator with frame-aligned duty updates
module pwm_serializer #(
    parameter int SYS_FREQ   = 50000000,
    parameter int PULSE_FREQ = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] duty_cycle,
    output logic       signal
);
    localparam int P  = SYS_FREQ / PULSE_FREQ;
    localparam int CW = (P < 2) ? 1 : $clog2(P);
    localparam int PW = 10 + CW;
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    generate
        if (P < 2) begin : g_bad_period
            $error("pwm_serializer: SYS_FREQ/PULSE_FREQ must be at least 2");
        end
    endgenerate

    logic [CW-1:0] counter;
    logic [CW-1:0] threshold;
    logic [PW-1:0] product;
    logic [CW-1:0] threshold_next;
    logic          wrap;

    // Full-width product keeps floor(duty*P/1024) exact before the shift.
    always_comb begin
        product        = {{CW{1'b0}}, duty_cycle} * PW'(P);
        threshold_next = CW'(product >> 10);
        wrap           = (counter == LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter   <= '0;
            threshold <= '0;
            signal    <= 1'b0;
        end else begin
            counter <= wrap ? '0 : counter + 1'b1;
            if (wrap)
                threshold <= threshold_next;
            signal <= (counter < threshold);
        end
    end
endmodule

// File: tb/tb_pwm_serializer.sv
// tb/tb_pwm_serializer.sv - directed frame-level checks of pwm_serializer
module tb_pwm_serializer;
    logic       clock = 1'b0;
    logic       reset;
    logic       reset_b;
    logic [9:0] duty;
    logic [9:0] duty_b;
    logic       signal;
    logic       signal_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pwm_serializer #(.SYS_FREQ(10240), .PULSE_FREQ(10)) dut (
        .clock      (clock),
        .reset      (reset),
        .duty_cycle (duty),
        .signal     (signal)
    );

    // Non-power-of-two frame (P=5000) to exercise the truncating divide.
    pwm_serializer #(.SYS_FREQ(50000000), .PULSE_FREQ(10000)) dut_b (
        .clock      (clock),
        .reset      (reset_b),
        .duty_cycle (duty_b),
        .signal     (signal_b)
    );

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Cycle i of a frame has pre-edge counter i, so signal must equal (i < th).
    task automatic run_frame(input string tag, input bit sel, input int n, input int th,
                             input int chg_at, input int chg_duty);
        int   hi  = 0;
        int   bad = 0;
        logic s;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            s = sel ? signal_b : signal;
            if (s === 1'b1) hi++;
            if (s !== (i < th)) bad++;
            if (i == chg_at) duty = 10'(chg_duty);
        end
        check({tag, " high count"}, hi, (n < th) ? n : th);
        check({tag, " shape errors"}, bad, 0);
    endtask

    initial begin
        int hi;
        reset   = 1'b1;
        reset_b = 1'b1;
        duty    = 10'd512;
        duty_b  = 10'd900;
        #1;
        check("reset initial signal", int'(signal), 0);
        check("reset initial signal_b", int'(signal_b), 0);

        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (signal !== 1'b0) hi++;
        end
        check("reset held with clock", hi, 0);

        reset = 1'b0;
        run_frame("f0 first frame low", 1'b0, 1024, 0, -1, 0);
        run_frame("f1 duty 512", 1'b0, 1024, 512, -1, 0);
        run_frame("f2 duty 512", 1'b0, 1024, 512, 0, 0);
        run_frame("f3 duty 0", 1'b0, 1024, 0, 0, 1023);
        run_frame("f4 duty 1023", 1'b0, 1024, 1023, -1, 0);
        run_frame("f5 duty 1023", 1'b0, 1024, 1023, 0, 100);
        run_frame("f6 duty 100 kept", 1'b0, 1024, 100, 299, 900);
        run_frame("f7 duty 900", 1'b0, 1024, 900, -1, 0);

        run_frame("f8 partial", 1'b0, 50, 900, -1, 0);
        check("pre-pulse signal high", int'(signal), 1);
        #2 reset = 1'b1;
        #1;
        check("async drop on reset", int'(signal), 0);
        @(negedge clock);
        check("signal during pulse", int'(signal), 0);
        reset = 1'b0;
        run_frame("f9 low after pulse", 1'b0, 1024, 0, -1, 0);
        run_frame("f10 duty 900 after pulse", 1'b0, 1024, 900, -1, 0);

        reset_b = 1'b0;
        run_frame("b0 first frame low", 1'b1, 5000, 0, -1, 0);
        run_frame("b1 duty 900 P5000", 1'b1, 5000, 4394, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
